// File: rtl/ddr_cmd_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ddr_cmd_rr_arbiter
//
// Round-robin arbiter sharing one DDR AXI-style command port between up to
// four requesters. A winner is picked in IDLE, its command is latched and
// presented with a valid/ready handshake, and the grant is held until the
// datapath pulses burst completion.
//
// Optional feature: define ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
// When it expires, the grant is released and the sticky timeout_err_o is set.
// Without the macro, WAIT holds indefinitely and timeout_err_o stays 0.
//
// Ports:
//   clk, rst_n       clock (rising edge), async active-low reset
//   req_i            per-requester request level
//   req_wr_i         per-requester direction (1 = write)
//   req_addr_i       packed addresses, requester i at [i*AW +: AW]
//   req_len_i        packed AXI len, requester i at [i*4 +: 4]
//   gnt_o            one-hot grant, held for the whole transaction
//   cmd_valid_o      command valid toward the controller
//   cmd_ready_i      controller accepts command
//   cmd_wr_o/cmd_addr_o/cmd_len_o  latched command fields
//   cmd_src_o        index of the granted requester
//   burst_done_p_i   one-cycle pulse: granted burst finished
//   busy_o           arbiter not idle
//   cmd_cnt_o        completed-transaction count (wraps)
//   err_clr_i        clears timeout_err_o
//   timeout_err_o    sticky timeout flag
// ----------------------------------------------------------------------------
module ddr_cmd_rr_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int TIMEOUT_CYC     = 1023
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_i,
    input  logic [NUM_REQ-1:0]                 req_wr_i,
    input  logic [NUM_REQ*CTRL_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*4-1:0]               req_len_i,
    output logic [NUM_REQ-1:0]                 gnt_o,
    output logic                               cmd_valid_o,
    input  logic                               cmd_ready_i,
    output logic                               cmd_wr_o,
    output logic [CTRL_ADDR_WIDTH-1:0]         cmd_addr_o,
    output logic [3:0]                         cmd_len_o,
    output logic [1:0]                         cmd_src_o,
    input  logic                               burst_done_p_i,
    output logic                               busy_o,
    output logic [15:0]                        cmd_cnt_o,
    input  logic                               err_clr_i,
    output logic                               timeout_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [1:0]                   last_q, last_d;
    logic [NUM_REQ-1:0]           gnt_q, gnt_d;
    logic                         cmd_valid_q, cmd_valid_d;
    logic                         cmd_wr_q, cmd_wr_d;
    logic [CTRL_ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic [3:0]                   cmd_len_q, cmd_len_d;
    logic [1:0]                   cmd_src_q, cmd_src_d;
    logic                         busy_q, busy_d;
    logic [15:0]                  cmd_cnt_q, cmd_cnt_d;
    logic                         timeout_err_q, timeout_err_d;

    logic [2:0]                   pick_s;      // {found, index}
    logic                         handshake_s;
    logic                         tmo_hit_s;
    logic [CTRL_ADDR_WIDTH-1:0]   addr_arr_s [NUM_REQ];
    logic [3:0]                   len_arr_s  [NUM_REQ];

    // First set request bit searching upward from last+1, wrapping at NUM_REQ.
    function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                           input logic [1:0]         last);
        logic [2:0] res;
        int         idx;
        logic [1:0] idx2;
        res = 3'b000;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx  = (int'(last) + 1 + k) % NUM_REQ;
            idx2 = idx[1:0];
            res  = (!res[2] && r[idx2]) ? {1'b1, idx2} : res;
        end
        return res;
    endfunction

    assign handshake_s = cmd_valid_q && cmd_ready_i;

    // Unpack per-requester address and length fields for indexed selection.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr_s[i] = req_addr_i[i*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH];
            len_arr_s[i]  = req_len_i[i*4 +: 4];
        end
    end

    // Winner selection for the next IDLE decision.
    always_comb begin
        pick_s = rr_pick(req_i, last_q);
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYC - 1);
    logic [9:0] tmo_cnt_q, tmo_cnt_d;

    // Watchdog expires on the WAIT cycle that would make the count reach TIMEOUT_CYC.
    assign tmo_hit_s = (state_q == ST_WAIT) && (tmo_cnt_q == TMO_LAST);

    // Watchdog counter: cleared on WAIT entry, counts every WAIT cycle.
    always_comb begin
        if (state_q != ST_WAIT) begin
            tmo_cnt_d = 10'd0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 10'd1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 10'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_q        <= 2'(NUM_REQ - 1);
            gnt_q         <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_wr_q      <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_len_q     <= 4'd0;
            cmd_src_q     <= 2'd0;
            busy_q        <= 1'b0;
            cmd_cnt_q     <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            gnt_q         <= gnt_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_wr_q      <= cmd_wr_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_len_q     <= cmd_len_d;
            cmd_src_q     <= cmd_src_d;
            busy_q        <= busy_d;
            cmd_cnt_q     <= cmd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic; completion takes priority over the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_s[2]) state_d = ST_ISSUE;
                else           state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                if (handshake_s) state_d = ST_WAIT;
                else             state_d = ST_ISSUE;
            end
            ST_WAIT: begin
                if (burst_done_p_i) state_d = ST_RELEASE;
                else if (tmo_hit_s) state_d = ST_RELEASE;
                else                state_d = ST_WAIT;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values, all held unless the current state updates them.
    always_comb begin
        last_d      = last_q;
        gnt_d       = gnt_q;
        cmd_valid_d = cmd_valid_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        cmd_src_d   = cmd_src_q;
        cmd_cnt_d   = cmd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_s[2]) begin
                    gnt_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s[1:0];
                    cmd_valid_d = 1'b1;
                    cmd_wr_d    = req_wr_i[pick_s[1:0]];
                    cmd_addr_d  = addr_arr_s[pick_s[1:0]];
                    cmd_len_d   = len_arr_s[pick_s[1:0]];
                    cmd_src_d   = pick_s[1:0];
                    last_d      = pick_s[1:0];
                end else begin
                    gnt_d       = gnt_q;
                end
            end
            ST_ISSUE: begin
                if (handshake_s) cmd_valid_d = 1'b0;
                else             cmd_valid_d = cmd_valid_q;
            end
            ST_WAIT: begin
                if (burst_done_p_i) cmd_cnt_d = cmd_cnt_q + 16'd1;
                else                cmd_cnt_d = cmd_cnt_q;
            end
            ST_RELEASE: gnt_d = '0;
            default:    gnt_d = '0;
        endcase
        busy_d = (state_d != ST_IDLE);
        // A new timeout in the same cycle as err_clr keeps the flag set.
        if (tmo_hit_s && !burst_done_p_i) begin
            timeout_err_d = 1'b1;
        end else if (err_clr_i) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    assign gnt_o         = gnt_q;
    assign cmd_valid_o   = cmd_valid_q;
    assign cmd_wr_o      = cmd_wr_q;
    assign cmd_addr_o    = cmd_addr_q;
    assign cmd_len_o     = cmd_len_q;
    assign cmd_src_o     = cmd_src_q;
    assign busy_o        = busy_q;
    assign cmd_cnt_o     = cmd_cnt_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_ddr_cmd_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ddr_cmd_rr_arbiter
//
// Self-checking bench for ddr_cmd_rr_arbiter: a per-cycle vector table for
// grant rotation and handshakes, followed by hand-written sequences for the
// long ready stall, WAIT hold or timeout, and asynchronous reset in WAIT.
// Requester i carries addr 0x100+i, len 7-i, write = i[0].
// ----------------------------------------------------------------------------
module tb_ddr_cmd_rr_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 28;
    localparam int TMO = 16;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_wr;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*4-1:0]   req_len;
    logic [NR-1:0]     gnt;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [AW-1:0]     cmd_addr;
    logic [3:0]        cmd_len;
    logic [1:0]        cmd_src;
    logic              burst_done;
    logic              busy;
    logic [15:0]       cmd_cnt;
    logic              err_clr;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;

    ddr_cmd_rr_arbiter #(
        .NUM_REQ(NR), .CTRL_ADDR_WIDTH(AW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_i(req), .req_wr_i(req_wr), .req_addr_i(req_addr), .req_len_i(req_len),
        .gnt_o(gnt), .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
        .cmd_wr_o(cmd_wr), .cmd_addr_o(cmd_addr), .cmd_len_o(cmd_len),
        .cmd_src_o(cmd_src), .burst_done_p_i(burst_done), .busy_o(busy),
        .cmd_cnt_o(cmd_cnt), .err_clr_i(err_clr), .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic        rdy;
        logic        done;
        logic [3:0]  e_gnt;
        logic        e_valid;
        logic [1:0]  e_src;
        logic        e_busy;
        logic [15:0] e_cnt;
    } row_t;

    row_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] r, input logic rdy, input logic done,
                       input logic [3:0] eg, input logic ev, input logic [1:0] es,
                       input logic eb, input logic [15:0] ec);
        row_t x;
        x.req = r; x.rdy = rdy; x.done = done; x.e_gnt = eg; x.e_valid = ev;
        x.e_src = es; x.e_busy = eb; x.e_cnt = ec;
        tbl.push_back(x);
    endtask

    // Command fields expected for the granted requester.
    task automatic chk_cmd(input string tag, input logic [1:0] s);
        logic [3:0] l;
        l = 4'd7 - {2'b00, s};
        chk({tag, ".src"},  32'(cmd_src),  32'(s));
        chk({tag, ".addr"}, 32'(cmd_addr), 32'h100 + 32'(s));
        chk({tag, ".len"},  32'(cmd_len),  32'(l));
        chk({tag, ".wr"},   32'(cmd_wr),   32'(s[0]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  oh;
        logic [1:0]  s;
        logic [15:0] c;
        clk = 1'b0; rst_n = 1'b0;
        req = '0; cmd_ready = 1'b0; burst_done = 1'b0; err_clr = 1'b0;
        req_wr = 4'b1010;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = 28'h100 + 28'(i);
            req_len[i*4 +: 4]    = 4'(7 - i);
        end

        // ---- vector table ----
        // single requester 0: grant, handshake, done, release
        add(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 16'd0);
        add(4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 16'd0);
        add(4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 16'd1);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 16'd1);
        // all four requesting: rotation 1,2,3,0,1 after last=0
        for (int t = 0; t < 5; t++) begin
            s  = 2'(t + 1);
            oh = 4'b0001 << s;
            c  = 16'(t + 1);
            add(4'b1111, 1'b1, 1'b0, oh,      1'b1, s, 1'b1, c);
            add(4'b1111, 1'b1, 1'b0, oh,      1'b0, s, 1'b1, c);
            add(4'b1111, 1'b1, 1'b1, oh,      1'b0, s, 1'b1, c + 16'd1);
            add(4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, s, 1'b0, c + 16'd1);
        end
        // done during ISSUE, and done together with handshake: both ignored
        add(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 16'd6);
        add(4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 16'd6);
        add(4'b0000, 1'b1, 1'b1, 4'b0010, 1'b0, 2'd1, 1'b1, 16'd6);
        add(4'b0000, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd1, 1'b1, 16'd7);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 16'd7);
        // idle with ready/done but no request: nothing happens
        add(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 16'd7);

        // ---- reset state ----
        repeat (2) step();
        chk("rst.gnt",   32'(gnt),         32'h0);
        chk("rst.valid", 32'(cmd_valid),   32'h0);
        chk("rst.addr",  32'(cmd_addr),    32'h0);
        chk("rst.len",   32'(cmd_len),     32'h0);
        chk("rst.src",   32'(cmd_src),     32'h0);
        chk("rst.wr",    32'(cmd_wr),      32'h0);
        chk("rst.busy",  32'(busy),        32'h0);
        chk("rst.cnt",   32'(cmd_cnt),     32'h0);
        chk("rst.terr",  32'(timeout_err), 32'h0);
        rst_n = 1'b1;

        // ---- apply table ----
        foreach (tbl[i]) begin
            req = tbl[i].req; cmd_ready = tbl[i].rdy; burst_done = tbl[i].done;
            step();
            chk($sformatf("row%0d.gnt", i),   32'(gnt),       32'(tbl[i].e_gnt));
            chk($sformatf("row%0d.valid", i), 32'(cmd_valid), 32'(tbl[i].e_valid));
            chk($sformatf("row%0d.busy", i),  32'(busy),      32'(tbl[i].e_busy));
            chk($sformatf("row%0d.cnt", i),   32'(cmd_cnt),   32'(tbl[i].e_cnt));
            if (tbl[i].e_gnt != 4'b0000) begin
                chk_cmd($sformatf("row%0d", i), tbl[i].e_src);
            end
        end
        req = '0; cmd_ready = 1'b0; burst_done = 1'b0;

        // ---- ready held low for 20 cycles (last=1, so requester 2 wins) ----
        req = 4'b0100;
        step();
        req = 4'b0000;
        chk("stall.gnt", 32'(gnt), 32'h4);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("stall%0d.valid", i), 32'(cmd_valid), 32'h1);
            chk($sformatf("stall%0d.gnt", i),   32'(gnt),       32'h4);
            chk($sformatf("stall%0d.busy", i),  32'(busy),      32'h1);
            chk_cmd($sformatf("stall%0d", i), 2'd2);
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk("stall.hs_valid", 32'(cmd_valid), 32'h0);
        chk("stall.hs_gnt",   32'(gnt),       32'h4);

`ifdef ARB_TIMEOUT_EN
        // ---- watchdog expiry in WAIT ----
        begin
            int n;
            n = 0;
            while (!timeout_err && n < 40) begin
                step();
                n++;
            end
            chk("tmo.flag", 32'(timeout_err), 32'h1);
            step();
            chk("tmo.gnt",  32'(gnt),     32'h0);
            chk("tmo.cnt",  32'(cmd_cnt), 32'd7);
            chk("tmo.busy", 32'(busy),    32'h0);
            err_clr = 1'b1;
            step();
            err_clr = 1'b0;
            chk("tmo.clr", 32'(timeout_err), 32'h0);
            // back into WAIT with requester 2 for the reset test
            req = 4'b0100;
            step();
            req = 4'b0000;
            cmd_ready = 1'b1;
            step();
            cmd_ready = 1'b0;
            chk("tmo.regnt", 32'(gnt), 32'h4);
        end
`else
        // ---- WAIT holds indefinitely without a done pulse ----
        repeat (40) step();
        chk("hold.gnt",  32'(gnt),         32'h4);
        chk("hold.busy", 32'(busy),        32'h1);
        chk("hold.terr", 32'(timeout_err), 32'h0);
        chk("hold.cnt",  32'(cmd_cnt),     32'd7);
`endif

        // ---- asynchronous reset while in WAIT with gnt=0100 ----
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst.gnt",   32'(gnt),       32'h0);
        chk("arst.valid", 32'(cmd_valid), 32'h0);
        chk("arst.busy",  32'(busy),      32'h0);
        chk("arst.cnt",   32'(cmd_cnt),   32'h0);
        chk("arst.addr",  32'(cmd_addr),  32'h0);
        chk("arst.len",   32'(cmd_len),   32'h0);
        #2;
        rst_n = 1'b1;
        req = 4'b0100;
        step();
        req = 4'b0000;
        chk("arst.regnt", 32'(gnt),       32'h4);
        chk("arst.valid2",32'(cmd_valid), 32'h1);
        chk_cmd("arst", 2'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_cmd_rr_arbiter.md
# ddr_cmd_rr_arbiter

Round-robin arbiter sharing a single DDR AXI-style command port between up to four traffic requesters (BIST write/read generators, frame-buffer engines). Grants one requester at a time, forwards its latched command with a valid/ready handshake, and holds the grant until the datapath reports burst completion. Sits between the requester sequencers and the DDR controller's AXI command front end.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..4.
- CTRL_ADDR_WIDTH, 28, command address width.
- TIMEOUT_CYC, 1023, WAIT cycles before abort; used only with ARB_TIMEOUT_EN; 10-bit counter.

- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester request level.
- req_wr  in  NUM_REQ  per-requester direction, 1 = write.
- req_addr  in  NUM_REQ*CTRL_ADDR_WIDTH  packed addresses, requester i at [i*AW +: AW].
- req_len  in  NUM_REQ*4  packed AXI len, requester i at [i*4 +: 4].
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- cmd_valid  out  1  command valid toward controller.
- cmd_ready  in  1  controller accepts command.
- cmd_wr  out  1  latched direction.
- cmd_addr  out  CTRL_ADDR_WIDTH  latched address.
- cmd_len  out  4  latched length.
- cmd_src  out  2  index of granted requester.
- burst_done_p  in  1  one-cycle pulse: granted burst finished on datapath.
- busy  out  1  state != IDLE.
- cmd_cnt  out  16  completed-transaction count, wraps 0xFFFF→0.
- err_clr  in  1  clears timeout_err.
- timeout_err  out  1  sticky timeout flag.

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE (2-bit encoding 0..3; illegal → IDLE).
- IDLE: if any req bit set, select winner = first set bit searching from (last+1) mod NUM_REQ upward with wrap; latch req_wr/req_addr/req_len of winner into cmd_*; set gnt[winner], cmd_src=winner, cmd_valid=1, last=winner; → ISSUE. No req: stay.
- ISSUE: cmd_* and gnt stable; on cmd_valid&cmd_ready clear cmd_valid → WAIT.
- WAIT: on burst_done_p → RELEASE, cmd_cnt+1. burst_done_p ignored in every other state.
- RELEASE: clear gnt → IDLE. Requester still asserting req is re-arbitrated normally (rotates behind others).
- Unused req bits above NUM_REQ-1 do not exist; gnt never has more than one bit set.
- Requester may drop req after grant; grant is not revoked until RELEASE.
- err_clr clears timeout_err in any state; a same-cycle new timeout wins (flag stays 1).

## Timing
- Reset values: gnt=0, cmd_valid=0, cmd_wr=0, cmd_addr=0, cmd_len=0, cmd_src=0, busy=0, cmd_cnt=0, timeout_err=0, state=IDLE, last=NUM_REQ-1 (requester 0 wins first).
- req sampled at cycle N in IDLE → gnt, cmd_valid, cmd_* valid at N+1.
- Handshake at cycle M → cmd_valid=0 at M+1.
- burst_done_p at K → cmd_cnt updated and state RELEASE at K+1, gnt=0 at K+2, earliest next grant K+3.
- cmd_ready with cmd_valid low has no effect; handshake and burst_done_p same cycle: pulse ignored.
- Reset mid-transaction: immediate return to reset values; no pending command retained.

## Configuration
- ARB_TIMEOUT_EN defined: 10-bit counter cleared on WAIT entry, increments each WAIT cycle; reaching TIMEOUT_CYC without burst_done_p sets timeout_err and forces RELEASE (cmd_cnt not incremented).
- Undefined: no counter; WAIT holds indefinitely; timeout_err tied 0.

## Test plan
- Reset, req=4'b0001, cmd_ready=1, addr0=0x100, len0=7 → next cycle gnt=0001, cmd_addr=0x100, cmd_len=7, cmd_src=0; done pulse → gnt=0 two cycles later, cmd_cnt=1.
- req=4'b1111 held, immediate ready/done each txn → grant order 0,1,2,3,0; no requester granted twice before all others.
- cmd_ready held low 20 cycles → cmd_valid and cmd_* stable all 20 cycles, state ISSUE; ready high → cmd_valid low next cycle.
- burst_done_p pulsed during ISSUE, then after handshake → first pulse ignored, cmd_cnt increments once.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=16, no done → timeout_err=1, gnt released, cmd_cnt unchanged; err_clr → timeout_err=0.
- rst_n low while in WAIT with gnt=0100 → all outputs at reset values asynchronously; after release req=0100 granted again.
